bus_demux4: RTL and testbench
=============================

BUS_DEMUX4 -- requirements
Module: bus_demux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data/address width in bits.
REQ-002 The block SHALL have parameters BASE0..BASE3, defaults 32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'hFFFF_0000, target base addresses.
REQ-003 The block SHALL have parameters MASK0..MASK3, defaults 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00, decode masks.
REQ-004 The block SHALL have parameter TIMEOUT, default 8'd255, maximum cycles a transaction stays outstanding.
REQ-005 Ports, in order, SHALL be:
- clk  in  1  sole clock; one clock domain, all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  master request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  WIDTH  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse; master always accepts.
- rsp_err  out  1  qualifies rsp_valid: decode miss or timeout.
- rsp_rdata  out  WIDTH  read data, 0 on error and on writes.
- s_valid  out  4  one-hot request to target i.
- s_ready  in  4  target i accepts.
- s_addr, s_we, s_be, s_wdata  out  WIDTH/1/4/WIDTH  registered copy of accepted request, shared by all targets.
- s_rsp_valid  in  4  target i response/ack.
- s_rsp_rdata  in  4*WIDTH  target i read data in bits [i*WIDTH +: WIDTH].

Function
REQ-006 Target i SHALL match when (req_addr & MASKi) == BASEi; on multiple matches the lowest index SHALL win.
REQ-007 FSM states SHALL be IDLE, REQ, RSP, DERR; exactly one transaction outstanding at any time.
REQ-008 req_ready SHALL be 1 only in IDLE; on acceptance the request and decoded index SHALL be registered and the FSM SHALL go to REQ on a match, DERR on no match.
REQ-009 In REQ, s_valid[sel] SHALL be 1 and all other s_valid bits 0; s_valid SHALL be held with stable s_* fields until s_ready[sel]=1, then the FSM SHALL go to RSP.
REQ-010 In RSP, s_valid SHALL be 0; when s_rsp_valid[sel]=1 the block SHALL, next cycle, pulse rsp_valid=1, rsp_err=0, rsp_rdata = selected slice (reads) or 0 (writes), and return to IDLE.
REQ-011 Minimum latency SHALL be: accept at cycle 0, s_valid at cycle 1, rsp_valid at cycle 3 when s_ready at cycle 1 and s_rsp_valid at cycle 2.
REQ-012 DERR SHALL last one cycle, with no s_valid asserted, followed by rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE.
REQ-013 An 8-bit timeout counter SHALL clear on acceptance and increment each cycle in REQ or RSP; on reaching TIMEOUT the block SHALL drop s_valid, pulse rsp_valid=1 with rsp_err=1 and rsp_rdata=0 next cycle, and return to IDLE.
REQ-014 If a response and the timeout occur in the same cycle, the response SHALL win.
REQ-015 s_rsp_valid from a non-selected target, or any s_rsp_valid while in IDLE, REQ or DERR, SHALL be ignored.
REQ-016 rsp_valid SHALL never be high for two consecutive cycles, and req_ready SHALL be 0 in the cycle rsp_valid is 1.

Reset
REQ-017 While rst=1: state=IDLE, s_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0, registered request=0; req_ready SHALL be 0 during reset and 1 in the first cycle after.
REQ-018 rst asserted mid-transaction SHALL abandon it with no response pulse; a later target response SHALL be ignored per REQ-015.

Structure
REQ-019 State encodings, target count (4) and default BASE/MASK values SHALL live in shared package bus_pkg.
REQ-020 Address decode SHALL be a combinational sub-module addr_dec4 (addr in; hit, idx[1:0] out); datapath selection SHALL reuse the codebase mux4 for rsp_rdata slice selection.

Verification
REQ-021 Read 0x0000_0010, target 0 ready at cycle 1 and rsp at cycle 2 with data 0xDEADBEEF -> s_valid=4'b0001 at cycle 1; rsp_valid, rsp_err=0, rsp_rdata=0xDEADBEEF at cycle 3.
REQ-022 Write 0x1000_0004, data 0x12345678, be 4'b0011, target 1 holds s_ready=0 for 3 cycles -> s_valid=4'b0010 held with stable s_* fields; write response returns rsp_rdata=0.
REQ-023 Read 0x3000_0000 (no match) -> no s_valid; rsp_valid=1, rsp_err=1, rsp_rdata=0 at cycle 2.
REQ-024 Target 2 accepts 0x2000_0000 but never responds -> rsp_err pulse exactly at TIMEOUT+1 cycles after accept; a target response injected afterward is ignored.
REQ-025 rst at cycle 2 of an outstanding read -> no rsp_valid; req_ready=1 in the first cycle after reset; the next request completes normally.
REQ-026 Target 3 rsp_valid while target 0 is selected -> ignored; only target 0 data returned.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the four-target bus demultiplexer: state encoding,
// target count and the default address map.
package bus_pkg;

    localparam int N_TGT = 4;

    localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
    localparam logic [31:0] DEF_BASE1 = 32'h1000_0000;
    localparam logic [31:0] DEF_BASE2 = 32'h2000_0000;
    localparam logic [31:0] DEF_BASE3 = 32'hFFFF_0000;

    localparam logic [31:0] DEF_MASK0 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_MASK1 = 32'hFFFF_F000;
    localparam logic [31:0] DEF_MASK2 = 32'hFFFF_F000;
    localparam logic [31:0] DEF_MASK3 = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DERR
    } state_e;

    function automatic logic [N_TGT-1:0] onehot(input logic [1:0] idx);
        logic [N_TGT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/addr_dec4.sv
// Combinational base/mask decoder for four targets; lowest matching index wins.
module addr_dec4
    import bus_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] BASE0 = WIDTH'(DEF_BASE0),
    parameter logic [WIDTH-1:0] BASE1 = WIDTH'(DEF_BASE1),
    parameter logic [WIDTH-1:0] BASE2 = WIDTH'(DEF_BASE2),
    parameter logic [WIDTH-1:0] BASE3 = WIDTH'(DEF_BASE3),
    parameter logic [WIDTH-1:0] MASK0 = WIDTH'(DEF_MASK0),
    parameter logic [WIDTH-1:0] MASK1 = WIDTH'(DEF_MASK1),
    parameter logic [WIDTH-1:0] MASK2 = WIDTH'(DEF_MASK2),
    parameter logic [WIDTH-1:0] MASK3 = WIDTH'(DEF_MASK3)
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic             hit_o,
    output logic [1:0]       idx_o
);

    logic [N_TGT-1:0] match;

    assign match[0] = (addr_i & MASK0) == BASE0;
    assign match[1] = (addr_i & MASK1) == BASE1;
    assign match[2] = (addr_i & MASK2) == BASE2;
    assign match[3] = (addr_i & MASK3) == BASE3;

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        hit_o = |match;
        idx_o = 2'd0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (match[i]) idx_o = 2'(i);
        end
    end

endmodule

// File: rtl/mux4.sv
// Generic 4:1 multiplexer.
module mux4 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  logic [1:0]   sel_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/bus_demux4.sv
// Single-outstanding bus demultiplexer: decodes a master request onto one of
// four targets and returns a response, a decode error or a timeout error.
module bus_demux4
    import bus_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] BASE0   = WIDTH'(DEF_BASE0),
    parameter logic [WIDTH-1:0] BASE1   = WIDTH'(DEF_BASE1),
    parameter logic [WIDTH-1:0] BASE2   = WIDTH'(DEF_BASE2),
    parameter logic [WIDTH-1:0] BASE3   = WIDTH'(DEF_BASE3),
    parameter logic [WIDTH-1:0] MASK0   = WIDTH'(DEF_MASK0),
    parameter logic [WIDTH-1:0] MASK1   = WIDTH'(DEF_MASK1),
    parameter logic [WIDTH-1:0] MASK2   = WIDTH'(DEF_MASK2),
    parameter logic [WIDTH-1:0] MASK3   = WIDTH'(DEF_MASK3),
    parameter logic [7:0]       TIMEOUT = 8'd255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic               req_we,
    input  logic [3:0]         req_be,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic [3:0]         s_valid,
    input  logic [3:0]         s_ready,
    output logic [WIDTH-1:0]   s_addr,
    output logic               s_we,
    output logic [3:0]         s_be,
    output logic [WIDTH-1:0]   s_wdata,
    input  logic [3:0]         s_rsp_valid,
    input  logic [4*WIDTH-1:0] s_rsp_rdata
);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rsp_v_q, rsp_v_d, rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             dec_hit;
    logic [1:0]       dec_idx;
    logic [WIDTH-1:0] sel_rdata;
    logic             accept, timeout_hit;

    addr_dec4 #(
        .WIDTH(WIDTH),
        .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
        .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3)
    ) u_dec (
        .addr_i (req_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    mux4 #(.W(WIDTH)) u_rmux (
        .d0_i  (s_rsp_rdata[0*WIDTH +: WIDTH]),
        .d1_i  (s_rsp_rdata[1*WIDTH +: WIDTH]),
        .d2_i  (s_rsp_rdata[2*WIDTH +: WIDTH]),
        .d3_i  (s_rsp_rdata[3*WIDTH +: WIDTH]),
        .sel_i (sel_q),
        .y_o   (sel_rdata)
    );

    // Ready is withheld while the response pulse is out so pulses never abut.
    assign req_ready   = !rst && (state_q == ST_IDLE) && !rsp_v_q;
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (cnt_q + 8'd1) == TIMEOUT;

    assign s_valid   = (!rst && state_q == ST_REQ) ? onehot(sel_q) : 4'b0000;
    assign s_addr    = addr_q;
    assign s_we      = we_q;
    assign s_be      = be_q;
    assign s_wdata   = wdata_q;
    assign rsp_valid = rsp_v_q && !rst;
    assign rsp_err   = rsp_err_q && !rst;
    assign rsp_rdata = rst ? '0 : rsp_data_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_v_d    = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
        case (state_q)
            ST_IDLE: if (accept) begin
                sel_d   = dec_idx;
                addr_d  = req_addr;
                we_d    = req_we;
                be_d    = req_be;
                wdata_d = req_wdata;
                cnt_d   = 8'd0;
                state_d = dec_hit ? ST_REQ : ST_DERR;
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    rsp_v_d   = 1'b1;
                    rsp_err_d = 1'b1;
                end else if (s_ready[sel_q]) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                cnt_d = cnt_q + 8'd1;
                // A target response beats a coincident timeout.
                if (s_rsp_valid[sel_q]) begin
                    state_d    = ST_IDLE;
                    rsp_v_d    = 1'b1;
                    rsp_data_d = we_q ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    rsp_v_d   = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            ST_DERR: begin
                state_d   = ST_IDLE;
                rsp_v_d   = 1'b1;
                rsp_err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= '0;
            cnt_q      <= 8'd0;
            rsp_v_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_v_q    <= rsp_v_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_bus_demux4.sv
// Bench for bus_demux4: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_bus_demux4;

    localparam int         TMO     = 20;
    localparam logic [31:0] TB_BASE [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'hFFFF_0000};
    localparam logic [31:0] TB_MASK [4] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00};

    logic         clk, rst;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_be;
    logic         rsp_valid, rsp_err;
    logic [31:0]  rsp_rdata;
    logic [3:0]   s_valid, s_ready, s_be, s_rsp_valid;
    logic [31:0]  s_addr, s_wdata;
    logic         s_we;
    logic [127:0] s_rsp_rdata;

    int checks = 0;
    int errors = 0;

    bus_demux4 #(.WIDTH(32), .TIMEOUT(8'(TMO))) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_we(s_we),
        .s_be(s_be), .s_wdata(s_wdata),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) if ((a & TB_MASK[i]) == TB_BASE[i]) return i;
        return -1;
    endfunction

    // Transaction-level model: one outstanding transaction, its age in cycles
    // since acceptance, and the response pulse due next cycle.
    bit          m_busy, m_hit, m_gnt, m_we, p_v, p_err, exp_rdy;
    int          m_idx, m_age;
    logic [31:0] m_addr, m_wdata, p_data;
    logic [3:0]  m_be, exp_sv;

    initial begin
        m_busy = 0; p_v = 0; p_err = 0; p_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("m_rst_ready", 32'(req_ready), 32'd0);
                chk("m_rst_rspv", 32'(rsp_valid), 32'd0);
                chk("m_rst_svalid", 32'(s_valid), 32'd0);
                m_busy = 0;
                p_v    = 0;
            end else begin
                exp_rdy = !m_busy && !p_v;
                chk("m_ready", 32'(req_ready), 32'(exp_rdy));
                chk("m_rspv", 32'(rsp_valid), 32'(p_v));
                chk("m_rsperr", 32'(rsp_err), 32'(p_v && p_err));
                chk("m_rdata", rsp_rdata, p_v ? p_data : 32'd0);
                exp_sv = (m_busy && m_hit && !m_gnt) ? 4'(1 << m_idx) : 4'd0;
                chk("m_svalid", 32'(s_valid), 32'(exp_sv));
                if (exp_sv != 0) begin
                    chk("m_saddr", s_addr, m_addr);
                    chk("m_swdata", s_wdata, m_wdata);
                    chk("m_sctl", 32'({s_we, s_be}), 32'({m_we, m_be}));
                end
                p_v = 0; p_err = 0; p_data = 0;
                if (m_busy) begin
                    if (!m_hit) begin
                        p_v = 1; p_err = 1; m_busy = 0;
                    end else if (m_gnt && s_rsp_valid[m_idx]) begin
                        p_v = 1; m_busy = 0;
                        p_data = m_we ? 32'd0 : s_rsp_rdata[m_idx*32 +: 32];
                    end else if (m_age == TMO) begin
                        p_v = 1; p_err = 1; m_busy = 0;
                    end else begin
                        if (!m_gnt && s_ready[m_idx]) m_gnt = 1;
                        m_age++;
                    end
                end else if (req_valid && exp_rdy) begin
                    m_busy  = 1;
                    m_idx   = decode(req_addr);
                    m_hit   = (m_idx >= 0);
                    if (!m_hit) m_idx = 0;
                    m_gnt   = 0;
                    m_age   = 1;
                    m_addr  = req_addr;
                    m_we    = req_we;
                    m_be    = req_be;
                    m_wdata = req_wdata;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        req_valid = 0; req_addr = 0; req_we = 0; req_be = 0; req_wdata = 0;
        s_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0;
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
        req_valid = 1; req_addr = a; req_we = we; req_be = be; req_wdata = d;
    endtask

    // Read from target 0 with the fastest possible handshake.
    task automatic rd_t0(input logic [31:0] d);
        issue(32'h0000_0010, 1'b0, 4'hF, 32'd0);
        @(negedge clk); chk("t0_ready", 32'(req_ready), 32'd1);
        tick; req_valid = 0; s_ready = 4'b0001;
        @(negedge clk); chk("t0_svalid_c1", 32'(s_valid), 32'h1);
        tick; s_ready = 0; s_rsp_valid = 4'b0001; s_rsp_rdata[31:0] = d;
        @(negedge clk); chk("t0_rspv_c2", 32'(rsp_valid), 32'd0);
        tick; s_rsp_valid = 0;
        @(negedge clk);
        chk("t0_rspv_c3", 32'(rsp_valid), 32'd1);
        chk("t0_err_c3", 32'(rsp_err), 32'd0);
        chk("t0_rdata_c3", rsp_rdata, d);
        chk("t0_ready_c3", 32'(req_ready), 32'd0);
        tick;
    endtask

    int mode;

    initial begin
        rst = 1;
        idle_in();
        repeat (3) tick;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_svalid", 32'(s_valid), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        tick; rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_saddr", s_addr, 32'd0);
        tick;

        rd_t0(32'hDEAD_BEEF);
        tick;

        // Write to target 1 with three stalled cycles.
        issue(32'h1000_0004, 1'b1, 4'b0011, 32'h1234_5678);
        tick; req_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("wr_svalid_hold", 32'(s_valid), 32'h2);
            chk("wr_saddr", s_addr, 32'h1000_0004);
            chk("wr_swdata", s_wdata, 32'h1234_5678);
            chk("wr_sctl", 32'({s_we, s_be}), 32'h13);
            tick;
        end
        s_ready = 4'b0010;
        @(negedge clk); chk("wr_svalid_c4", 32'(s_valid), 32'h2);
        tick; s_ready = 0; s_rsp_valid = 4'b0010; s_rsp_rdata[63:32] = 32'hAAAA_5555;
        tick; s_rsp_valid = 0;
        @(negedge clk);
        chk("wr_rspv", 32'(rsp_valid), 32'd1);
        chk("wr_err", 32'(rsp_err), 32'd0);
        chk("wr_rdata", rsp_rdata, 32'd0);
        tick; tick;

        // Decode miss.
        issue(32'h3000_0000, 1'b0, 4'hF, 32'd0);
        tick; req_valid = 0;
        @(negedge clk);
        chk("miss_svalid", 32'(s_valid), 32'd0);
        chk("miss_rspv_c1", 32'(rsp_valid), 32'd0);
        tick;
        @(negedge clk);
        chk("miss_rspv_c2", 32'(rsp_valid), 32'd1);
        chk("miss_err_c2", 32'(rsp_err), 32'd1);
        chk("miss_rdata_c2", rsp_rdata, 32'd0);
        tick; tick;

        // Target 2 accepts but never responds.
        issue(32'h2000_0000, 1'b0, 4'hF, 32'd0);
        tick; req_valid = 0; s_ready = 4'b0100;
        @(negedge clk); chk("tmo_svalid", 32'(s_valid), 32'h4);
        tick; s_ready = 0;
        for (int c = 2; c <= TMO; c++) begin
            @(negedge clk); chk("tmo_quiet", 32'(rsp_valid), 32'd0);
            tick;
        end
        @(negedge clk);
        chk("tmo_rspv", 32'(rsp_valid), 32'd1);
        chk("tmo_err", 32'(rsp_err), 32'd1);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        tick; s_rsp_valid = 4'b0100; s_rsp_rdata[95:64] = 32'h5555_AAAA;
        @(negedge clk); chk("tmo_late_c22", 32'(rsp_valid), 32'd0);
        tick; s_rsp_valid = 0;
        @(negedge clk);
        chk("tmo_late_c23", 32'(rsp_valid), 32'd0);
        chk("tmo_ready_c23", 32'(req_ready), 32'd1);
        tick;

        // Reset mid-read, then a stale target response.
        issue(32'h0000_0010, 1'b0, 4'hF, 32'd0);
        tick; req_valid = 0; s_ready = 4'b0001;
        tick; s_ready = 0; rst = 1; s_rsp_valid = 4'b0001; s_rsp_rdata[31:0] = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("mrst_ready_c2", 32'(req_ready), 32'd0);
        chk("mrst_rspv_c2", 32'(rsp_valid), 32'd0);
        tick; rst = 0;
        @(negedge clk);
        chk("mrst_ready_c3", 32'(req_ready), 32'd1);
        chk("mrst_rspv_c3", 32'(rsp_valid), 32'd0);
        tick; s_rsp_valid = 0;
        @(negedge clk); chk("mrst_rspv_c4", 32'(rsp_valid), 32'd0);
        tick;
        rd_t0(32'hCAFE_F00D);

        // Response from a non-selected target.
        issue(32'h0000_0010, 1'b0, 4'hF, 32'd0);
        tick; req_valid = 0; s_ready = 4'b0001;
        tick; s_ready = 0; s_rsp_valid = 4'b1000;
        s_rsp_rdata = {32'hBAD0_BAD0, 32'd0, 32'd0, 32'h1111_1111};
        tick; s_rsp_valid = 4'b0001; s_rsp_rdata[31:0] = 32'h600D_600D;
        @(negedge clk); chk("xt_rspv_c3", 32'(rsp_valid), 32'd0);
        tick; s_rsp_valid = 0;
        @(negedge clk);
        chk("xt_rspv_c4", 32'(rsp_valid), 32'd1);
        chk("xt_rdata_c4", rsp_rdata, 32'h600D_600D);
        tick;

        // Randomized traffic; mode shapes target behaviour to reach timeouts.
        for (int n = 0; n < 4000; n++) begin
            if (n % 100 == 0) mode = int'($urandom_range(3, 0));
            rst       = ($urandom_range(299, 0) == 0);
            req_valid = $urandom_range(1, 0) == 1;
            req_we    = $urandom_range(1, 0) == 1;
            req_be    = 4'($urandom_range(15, 0));
            req_wdata = $urandom;
            case ($urandom_range(4, 0))
                0:       req_addr = {16'h0000, 16'($urandom)};
                1:       req_addr = {20'h10000, 12'($urandom)};
                2:       req_addr = {20'h20000, 12'($urandom)};
                3:       req_addr = {24'hFFFF00, 8'($urandom)};
                default: req_addr = $urandom;
            endcase
            s_ready     = (mode == 3) ? 4'd0 : 4'($urandom_range(15, 0));
            s_rsp_valid = 4'd0;
            for (int b = 0; b < 4; b++) begin
                case (mode)
                    0:       s_rsp_valid[b] = $urandom_range(1, 0) == 1;
                    1:       s_rsp_valid[b] = $urandom_range(7, 0) == 0;
                    default: s_rsp_valid[b] = 1'b0;
                endcase
            end
            s_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick;
        end
        rst = 0;
        idle_in();
        tick; tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
